apuf_eval_ctrl: RTL and testbench
=================================

APUF_EVAL_CTRL -- requirements
Module: apuf_eval_ctrl

Interface
REQ-001 SHALL have parameter CHAL_W, default 22, the arbiter chain challenge width.
REQ-002 SHALL have parameter N_EVAL, default 7, the evaluations per challenge; odd, 1..15.
REQ-003 SHALL have parameter SETTLE_CYC, default 8, the clk cycles per precharge phase and per race phase; min 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port chal_in, input, CHAL_W, the challenge offered by the source.
REQ-007 SHALL have port chal_valid, input, 1, the source asserts that chal_in is valid.
REQ-008 SHALL have port chal_ready, output, 1, the block can accept a challenge.
REQ-009 SHALL have port puf_chal, output, CHAL_W, registered challenge driven to the arbiter chain.
REQ-010 SHALL have ports puf_x and puf_y, output, 1 each, registered race launch signals to the chain top and bottom inputs.
REQ-011 SHALL have port puf_q, input, 1, the arbiter flip-flop output; asynchronous to clk.
REQ-012 SHALL have port resp_valid, output, 1, the voted response is available.
REQ-013 SHALL have port resp_ready, input, 1, the sink accepts the response.
REQ-014 SHALL have port resp_bit, output, 1, the majority-voted response.
REQ-015 SHALL have port resp_ones, output, clog2(N_EVAL+1), the count of evaluations that returned 1.
REQ-016 SHALL have port resp_stable, output, 1, high when all N_EVAL evaluations agreed.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ARM, FIRE, SAMPLE, DONE.
REQ-019 SHALL drive chal_ready=1 only in IDLE; a handshake (chal_valid&&chal_ready) latches chal_in into puf_chal, clears eval_cnt and ones_cnt, and moves to ARM.
REQ-020 SHALL ignore chal_valid outside IDLE; puf_chal SHALL stay constant from the handshake until the next handshake.
REQ-021 ARM: puf_x=puf_y=0 for exactly SETTLE_CYC cycles, then go to FIRE.
REQ-022 FIRE: puf_x=puf_y=1, both changed on the same edge from the same registered state bit, for exactly SETTLE_CYC cycles, then go to SAMPLE.
REQ-023 SHALL pass puf_q through a 2-flop synchronizer running continuously.
REQ-024 SAMPLE: lasts exactly 2 cycles with puf_x=puf_y=1; on its last cycle add the synchronizer output to ones_cnt and increment eval_cnt.
REQ-025 After SAMPLE: go to DONE if the incremented eval_cnt==N_EVAL, else go to ARM.
REQ-026 Per-evaluation length SHALL be 2*SETTLE_CYC+2 cycles (18 at defaults); resp_valid SHALL rise N_EVAL*(2*SETTLE_CYC+2) cycles after the handshake edge (126 at defaults).
REQ-027 DONE: resp_valid=1, puf_x=puf_y=0; resp_bit=(ones_cnt>N_EVAL/2); resp_ones=ones_cnt; resp_stable=(ones_cnt==0 || ones_cnt==N_EVAL).
REQ-028 resp_* SHALL stay stable while resp_valid && !resp_ready; resp_valid&&resp_ready SHALL return the FSM to IDLE on the next edge.
REQ-029 A simultaneous chal_valid in the DONE→IDLE cycle SHALL NOT be accepted, because chal_ready=0 in DONE.
REQ-030 Counters SHALL saturate at no value; ones_cnt<=eval_cnt<=N_EVAL by construction.

Reset
REQ-031 On rst, at any state including mid-race, SHALL go to IDLE and set puf_x=puf_y=0, puf_chal=0, eval_cnt=ones_cnt=0, resp_valid=0, resp_bit=0, resp_ones=0, resp_stable=0, and clear the synchronizer flops.
REQ-032 chal_ready SHALL be 0 during rst and 1 on the first cycle after rst deasserts.

Structure
REQ-033 CHAL_W, N_EVAL, SETTLE_CYC defaults and the FSM state enum SHALL live in shared package apuf_pkg.
REQ-034 The synchronizer SHALL be a sub-module, sync_2ff; all else inline.
REQ-035 All outputs SHALL be registered; no combinational path from puf_q to any output.

Verification
REQ-036 The bench SHALL cover: puf_q model stuck 1, challenge 22'h2AAAAA -> resp_valid at cycle 126, resp_bit=1, resp_ones=7, resp_stable=1, puf_chal=22'h2AAAAA.
REQ-037 The bench SHALL cover: puf_q returns 1 on evaluations 1,3,5 only -> resp_bit=0, resp_ones=3, resp_stable=0.
REQ-038 The bench SHALL cover: resp_ready held low 20 cycles after resp_valid -> outputs frozen, chal_ready=0, chal_valid pulses ignored; IDLE on the cycle after resp_ready=1.
REQ-039 The bench SHALL cover: rst asserted in FIRE of evaluation 4 -> next cycle puf_x=puf_y=0, busy=0, puf_chal=0, chal_ready=1 after release.
REQ-040 The bench SHALL cover: back-to-back challenges 22'h000001 then 22'h3FFFFF -> second accepted only after first response handshake; puf_x and puf_y always equal; ARM and FIRE widths exactly 8 cycles.

Source files
------------

// File: rtl/apuf_pkg.sv
// Shared defaults and FSM state type for the arbiter-PUF evaluation controller.
// No ports; imported by apuf_eval_ctrl.
package apuf_pkg;

  localparam int CHAL_W_DEF     = 22;
  localparam int N_EVAL_DEF     = 7;
  localparam int SETTLE_CYC_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FIRE,
    S_SAMPLE,
    S_DONE
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous arbiter output.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: latches a challenge, runs N_EVAL
// precharge/race/sample evaluations and majority-votes the response.
// Ports: clk, rst; chal_in/chal_valid/chal_ready (challenge in);
// puf_chal/puf_x/puf_y/puf_q (arbiter chain); resp_valid/resp_ready,
// resp_bit/resp_ones/resp_stable (voted response); busy.
module apuf_eval_ctrl
  import apuf_pkg::*;
#(
  parameter int CHAL_W     = CHAL_W_DEF,
  parameter int N_EVAL     = N_EVAL_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHAL_W-1:0]              chal_in,
  input  logic                           chal_valid,
  output logic                           chal_ready,
  output logic [CHAL_W-1:0]              puf_chal,
  output logic                           puf_x,
  output logic                           puf_y,
  input  logic                           puf_q,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_bit,
  output logic [$clog2(N_EVAL+1)-1:0]    resp_ones,
  output logic                           resp_stable,
  output logic                           busy
);

  localparam int CW = $clog2(N_EVAL+1);
  localparam int TW = $clog2(SETTLE_CYC);

  localparam logic [TW-1:0] T_LAST = TW'(SETTLE_CYC-1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [CW-1:0] N_ALL  = CW'(N_EVAL);
  localparam logic [CW-1:0] N_HALF = CW'(N_EVAL/2);

  state_t        state;
  logic [TW-1:0] tmr;
  logic [CW-1:0] eval_cnt;
  logic [CW-1:0] ones_cnt;
  logic [CW-1:0] eval_nx;
  logic [CW-1:0] ones_nx;
  logic          fire_q;
  logic          q_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (puf_q),
    .q   (q_s)
  );

  // One register launches both race inputs so they can never skew.
  assign puf_x = fire_q;
  assign puf_y = fire_q;

  assign eval_nx = eval_cnt + CW'(1);
  assign ones_nx = ones_cnt + CW'(q_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tmr         <= '0;
      eval_cnt    <= '0;
      ones_cnt    <= '0;
      fire_q      <= 1'b0;
      puf_chal    <= '0;
      chal_ready  <= 1'b0;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_bit    <= 1'b0;
      resp_ones   <= '0;
      resp_stable <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          chal_ready <= 1'b1;
          if (chal_valid && chal_ready) begin
            puf_chal   <= chal_in;
            eval_cnt   <= '0;
            ones_cnt   <= '0;
            tmr        <= '0;
            chal_ready <= 1'b0;
            busy       <= 1'b1;
            state      <= S_ARM;
          end
        end
        S_ARM: begin
          if (tmr == T_LAST) begin
            tmr    <= '0;
            fire_q <= 1'b1;
            state  <= S_FIRE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_FIRE: begin
          if (tmr == T_LAST) begin
            tmr   <= '0;
            state <= S_SAMPLE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        // Two cycles give the synchronizer time to settle on the
        // arbiter decision before it is counted.
        S_SAMPLE: begin
          if (tmr == T_ONE) begin
            tmr      <= '0;
            fire_q   <= 1'b0;
            ones_cnt <= ones_nx;
            eval_cnt <= eval_nx;
            if (eval_nx == N_ALL) begin
              resp_valid  <= 1'b1;
              resp_bit    <= ones_nx > N_HALF;
              resp_ones   <= ones_nx;
              resp_stable <= (ones_nx == '0) ||
                             (ones_nx == N_ALL);
              state       <= S_DONE;
            end else begin
              state <= S_ARM;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            chal_ready <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Self-checking bench for apuf_eval_ctrl with a behavioural arbiter model
// driven by a per-evaluation response pattern.
module tb_apuf_eval_ctrl;

  localparam int W   = 22;
  localparam int N   = 7;
  localparam int LAT = 126;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] chal_in;
  logic         chal_valid;
  logic         chal_ready;
  logic [W-1:0] puf_chal;
  logic         puf_x;
  logic         puf_y;
  logic         puf_q;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_bit;
  logic [2:0]   resp_ones;
  logic         resp_stable;
  logic         busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic        stuck = 1'b0;
  logic [15:0] pat   = '0;
  int          ev_cnt  = 0;
  int          ev_base = 0;
  logic [3:0]  pidx;

  always #5 clk = ~clk;

  apuf_eval_ctrl #(
    .CHAL_W     (W),
    .N_EVAL     (N),
    .SETTLE_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .chal_in     (chal_in),
    .chal_valid  (chal_valid),
    .chal_ready  (chal_ready),
    .puf_chal    (puf_chal),
    .puf_x       (puf_x),
    .puf_y       (puf_y),
    .puf_q       (puf_q),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_bit    (resp_bit),
    .resp_ones   (resp_ones),
    .resp_stable (resp_stable),
    .busy        (busy)
  );

  // Arbiter model: evaluation i (0-based) resolves to pat[i] while racing.
  always @(negedge puf_x) ev_cnt++;
  assign pidx  = 4'(ev_cnt - ev_base);
  assign puf_q = stuck | (puf_x & pat[pidx]);

  // Launch-waveform monitor.
  logic mon_en = 1'b0;
  logic prev_x;
  int   xy_bad, low_run, hi_run, n_rise, n_fall;
  int   low_min, low_max, hi_min, hi_max;

  always @(negedge clk) begin
    if (!mon_en) begin
      prev_x = 1'b0; xy_bad = 0;
      low_run = 0; hi_run = 0;
      n_rise = 0; n_fall = 0;
      low_min = 1000; low_max = 0;
      hi_min = 1000; hi_max = 0;
    end else begin
      if (puf_x !== puf_y) xy_bad++;
      if (puf_x && !prev_x) begin
        if (low_run < low_min) low_min = low_run;
        if (low_run > low_max) low_max = low_run;
        n_rise++;
        hi_run = 1;
      end else if (puf_x) begin
        hi_run++;
      end else if (prev_x) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        n_fall++;
        low_run = busy ? 1 : 0;
      end else begin
        low_run = busy ? low_run + 1 : 0;
      end
      prev_x = puf_x;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_chal(input logic [W-1:0] c);
    int n = 0;
    while (!chal_ready && n < 50) begin
      tick();
      n++;
    end
    total_cnt++;
    if (!chal_ready)
      $display("FAIL start_ready: chal_ready=%b want 1", chal_ready);
    else
      pass_cnt++;
    ev_base    = ev_cnt;
    chal_in    = c;
    chal_valid = 1'b1;
    tick();
    chal_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic check_resp(input string nm, input logic [W-1:0] c,
                            input int lat);
    int  e_ones;
    logic e_bit, e_st;
    e_ones = stuck ? N : $countones(pat[N-1:0]);
    e_bit  = e_ones > N / 2;
    e_st   = (e_ones == 0) || (e_ones == N);
    total_cnt++;
    if (lat !== LAT)
      $display("FAIL %s_lat: got %0d want %0d", nm, lat, LAT);
    else pass_cnt++;
    total_cnt++;
    if (resp_bit !== e_bit)
      $display("FAIL %s_bit: got %b want %b", nm, resp_bit, e_bit);
    else pass_cnt++;
    total_cnt++;
    if (int'(resp_ones) !== e_ones)
      $display("FAIL %s_ones: got %0d want %0d", nm, resp_ones, e_ones);
    else pass_cnt++;
    total_cnt++;
    if (resp_stable !== e_st)
      $display("FAIL %s_stable: got %b want %b", nm, resp_stable, e_st);
    else pass_cnt++;
    total_cnt++;
    if (puf_chal !== c)
      $display("FAIL %s_chal: got %h want %h", nm, puf_chal, c);
    else pass_cnt++;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if ({chal_ready, busy, puf_x, puf_y, resp_valid} !== 5'b0)
      $display("FAIL reset_ctl: got %b want 00000",
               {chal_ready, busy, puf_x, puf_y, resp_valid});
    else pass_cnt++;
    total_cnt++;
    if ({puf_chal, resp_bit, resp_ones, resp_stable} !== '0)
      $display("FAIL reset_data: chal=%h bit=%b ones=%0d st=%b want 0",
               puf_chal, resp_bit, resp_ones, resp_stable);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (chal_ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", chal_ready);
    else pass_cnt++;
  endtask

  task automatic test_stuck_one();
    int lat;
    stuck = 1'b1;
    start_chal(22'h2AAAAA);
    wait_resp(lat);
    check_resp("stuck1", 22'h2AAAAA, lat);
    release_resp();
    stuck = 1'b0;
  endtask

  task automatic test_odd_evals();
    int lat;
    pat = 16'b0000_0000_0001_0101;
    start_chal(22'h155555);
    wait_resp(lat);
    check_resp("odd135", 22'h155555, lat);
    release_resp();
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] c;
    for (int i = 0; i < 4; i++) begin
      pat = (i == 0) ? 16'h0 : 16'($urandom);
      c   = W'($urandom);
      start_chal(c);
      wait_resp(lat);
      check_resp($sformatf("rnd%0d", i), c, lat);
      release_resp();
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [W-1:0] c;
    logic [5:0] snap;
    pat = 16'($urandom);
    c   = W'($urandom);
    start_chal(c);
    wait_resp(lat);
    check_resp("stall", c, lat);
    snap = {resp_valid, resp_bit, resp_ones, resp_stable};
    for (int i = 0; i < 20; i++) begin
      chal_in    = W'($urandom);
      chal_valid = 1'($urandom);
      tick();
      total_cnt++;
      if ({resp_valid, resp_bit, resp_ones, resp_stable} !== snap ||
          chal_ready !== 1'b0 || puf_chal !== c)
        $display("FAIL stall_hold%0d: resp=%b rdy=%b chal=%h want %b 0 %h",
                 i, {resp_valid, resp_bit, resp_ones, resp_stable},
                 chal_ready, puf_chal, snap, c);
      else pass_cnt++;
    end
    chal_valid = 1'b1;
    resp_ready = 1'b1;
    tick();
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    total_cnt++;
    if ({resp_valid, busy, chal_ready} !== 3'b001)
      $display("FAIL stall_idle: valid/busy/ready=%b want 001",
               {resp_valid, busy, chal_ready});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || puf_chal !== c)
      $display("FAIL done_chal_ignored: busy=%b chal=%h want 0 %h",
               busy, puf_chal, c);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int   rises = 0;
    int   n = 0;
    logic px = 1'b0;
    pat = 16'($urandom);
    start_chal(22'h0F0F0F);
    while (rises < 4 && n < 200) begin
      tick();
      n++;
      if (puf_x && !px) rises++;
      px = puf_x;
    end
    repeat (3) tick();
    total_cnt++;
    if (puf_x !== 1'b1)
      $display("FAIL mid_in_fire: puf_x=%b want 1", puf_x);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if ({puf_x, puf_y, busy, resp_valid, chal_ready} !== 5'b0 ||
        puf_chal !== '0)
      $display("FAIL mid_reset: ctl=%b chal=%h want 00000 0",
               {puf_x, puf_y, busy, resp_valid, chal_ready}, puf_chal);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (chal_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL mid_release: ready=%b busy=%b want 1 0",
               chal_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    mon_en = 1'b1;
    pat = 16'($urandom);
    start_chal(22'h000001);
    wait_resp(lat);
    check_resp("b2b_a", 22'h000001, lat);
    chal_in    = 22'h3FFFFF;
    chal_valid = 1'b1;
    repeat (5) tick();
    total_cnt++;
    if (puf_chal !== 22'h000001 || busy !== 1'b1)
      $display("FAIL b2b_early: chal=%h busy=%b want 000001 1",
               puf_chal, busy);
    else pass_cnt++;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || puf_chal !== 22'h000001)
      $display("FAIL b2b_idle: busy=%b chal=%h want 0 000001",
               busy, puf_chal);
    else pass_cnt++;
    ev_base = ev_cnt;
    pat = 16'($urandom);
    tick();
    chal_valid = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || puf_chal !== 22'h3FFFFF)
      $display("FAIL b2b_accept: busy=%b chal=%h want 1 3fffff",
               busy, puf_chal);
    else pass_cnt++;
    wait_resp(lat);
    check_resp("b2b_b", 22'h3FFFFF, lat);
    release_resp();
    tick();
    total_cnt++;
    if (xy_bad !== 0)
      $display("FAIL xy_equal: got %0d diffs want 0", xy_bad);
    else pass_cnt++;
    total_cnt++;
    if (n_rise !== 2 * N || n_fall !== 2 * N)
      $display("FAIL race_count: rise=%0d fall=%0d want %0d",
               n_rise, n_fall, 2 * N);
    else pass_cnt++;
    total_cnt++;
    if (low_min !== 8 || low_max !== 8)
      $display("FAIL arm_width: min=%0d max=%0d want 8", low_min, low_max);
    else pass_cnt++;
    // High run is FIRE (8) plus SAMPLE (2).
    total_cnt++;
    if (hi_min !== 10 || hi_max !== 10)
      $display("FAIL fire_width: min=%0d max=%0d want 10", hi_min, hi_max);
    else pass_cnt++;
    mon_en = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    chal_in    = '0;
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    test_reset();
    test_stuck_one();
    test_odd_evals();
    test_random();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
